// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : coin codes, credit constants and coin-driver state encoding
// Revision : 1.0
// ============================================================================
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam int PRICE       = 20;
  localparam int STEP_5      = 5;
  localparam int STEP_10     = 10;
  localparam int CREDIT_UNIT = 5;

  typedef logic [1:0] drv_state_t;

  localparam drv_state_t ST_IDLE  = 2'd0;
  localparam drv_state_t ST_DRIVE = 2'd1;
  localparam drv_state_t ST_GAP   = 2'd2;
  localparam drv_state_t ST_DONE  = 2'd3;

  // Illegal codes never reach the machine; they are replaced by an idle code.
  function automatic logic [1:0] drive_code(input logic [1:0] code);
    return (code == COIN_BAD) ? COIN_NONE : code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_coin_driver_credit_model.sv
`default_nettype none
// ============================================================================
// vend_credit_model : reference credit update, credit held in 5-cent units
// Revision          : 1.0
// ============================================================================
module vend_credit_model
  import vend_pkg::*;
(
  input  logic [1:0] credit,
  input  logic [1:0] coin,
  output logic [1:0] next_credit,
  output logic       exp_vend,
  output logic       exp_chg
);

  logic [2:0] w_step;
  logic [2:0] w_sum;

  always_comb begin
    w_step = 3'd0;
    case (coin)
      COIN_5:  w_step = 3'(STEP_5 / CREDIT_UNIT);
      COIN_10: w_step = 3'(STEP_10 / CREDIT_UNIT);
      default: w_step = 3'd0;
    endcase

    w_sum       = {1'b0, credit} + w_step;
    next_credit = w_sum[1:0];
    exp_vend    = 1'b0;
    exp_chg     = 1'b0;

    // Highest reachable sum is 15 + 10 = 25, so only two vend cases exist.
    if (w_sum == 3'(PRICE / CREDIT_UNIT)) begin
      exp_vend    = 1'b1;
      next_credit = 2'd0;
    end else if (w_sum == 3'((PRICE + STEP_5) / CREDIT_UNIT)) begin
      exp_vend    = 1'b1;
      exp_chg     = 1'b1;
      next_credit = 2'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_coin_driver.sv
`default_nettype none
// ============================================================================
// vend_coin_driver : drives coin commands onto the vending machine and checks it
// Revision         : 1.0
// ============================================================================
module vend_coin_driver
  import vend_pkg::*;
#(
  parameter int MAX_COINS = 4,
  parameter int GAP       = 1,
  parameter int CW        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2*MAX_COINS-1:0] cmd_coins,
  input  logic [CW-1:0]          cmd_len,
  output logic [1:0]             coin,
  input  logic                   dispense,
  input  logic                   chg5,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [CW-1:0]          rsp_vend,
  output logic [CW-1:0]          rsp_chg,
  output logic                   rsp_err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] c_max_len  = CW'(MAX_COINS);
  localparam logic [GW-1:0] c_gap_last = GW'(GAP - 1);

  drv_state_t             r_state;
  logic [2*MAX_COINS-1:0] r_coins;
  logic [CW-1:0]          r_len;
  logic [CW-1:0]          r_idx;
  logic [GW-1:0]          r_gap;
  logic [1:0]             r_coin;
  logic [1:0]             r_credit;
  logic [CW-1:0]          r_vend;
  logic [CW-1:0]          r_chg;
  logic                   r_err;
  logic                   r_exp_vend;
  logic                   r_exp_chg;
  logic                   r_seen_vend;
  logic                   r_seen_chg;

  logic [2*MAX_COINS-1:0] w_shift;
  logic [1:0]             w_slot;
  logic [1:0]             w_next_credit;
  logic                   w_exp_vend;
  logic                   w_exp_chg;
  logic                   w_win_vend;
  logic                   w_win_chg;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == '1) ? x : x + CW'(1);
  endfunction

  assign w_shift    = r_coins >> {r_idx, 1'b0};
  assign w_slot     = w_shift[1:0];
  assign w_win_vend = r_seen_vend | dispense;
  assign w_win_chg  = r_seen_chg | chg5;

  vend_credit_model u_model (
    .credit      (r_credit),
    .coin        (w_slot),
    .next_credit (w_next_credit),
    .exp_vend    (w_exp_vend),
    .exp_chg     (w_exp_chg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_coins     <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_coin      <= COIN_NONE;
      r_credit    <= 2'd0;
      r_vend      <= '0;
      r_chg       <= '0;
      r_err       <= 1'b0;
      r_exp_vend  <= 1'b0;
      r_exp_chg   <= 1'b0;
      r_seen_vend <= 1'b0;
      r_seen_chg  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_coins <= cmd_coins;
            r_len   <= cmd_len;
            r_idx   <= '0;
            r_vend  <= '0;
            r_chg   <= '0;
            r_err   <= 1'b0;
            if (cmd_len == '0) begin
              r_state <= ST_DONE;
            end else if (cmd_len > c_max_len) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_coin  <= drive_code(cmd_coins[1:0]);
              r_state <= ST_DRIVE;
            end
          end else if (dispense || chg5) begin
            r_err <= 1'b1;
            if (dispense) r_vend <= sat_inc(r_vend);
            if (chg5)     r_chg  <= sat_inc(r_chg);
          end
        end

        ST_DRIVE: begin
          r_credit    <= w_next_credit;
          r_exp_vend  <= w_exp_vend;
          r_exp_chg   <= w_exp_chg;
          r_seen_vend <= dispense;
          r_seen_chg  <= chg5;
          if (w_slot == COIN_BAD) r_err <= 1'b1;
          r_idx   <= r_idx + CW'(1);
          r_coin  <= COIN_NONE;
          r_gap   <= '0;
          r_state <= ST_GAP;
        end

        ST_GAP: begin
          // First gap cycle closes the response window opened in DRIVE.
          if (r_gap == '0) begin
            if ((w_win_vend != r_exp_vend) || (w_win_chg != r_exp_chg)) r_err <= 1'b1;
            if (w_win_vend) r_vend <= sat_inc(r_vend);
            if (w_win_chg)  r_chg  <= sat_inc(r_chg);
          end else if (dispense || chg5) begin
            r_err <= 1'b1;
            if (dispense) r_vend <= sat_inc(r_vend);
            if (chg5)     r_chg  <= sat_inc(r_chg);
          end

          if (r_gap == c_gap_last) begin
            if (r_idx < r_len) begin
              r_coin  <= drive_code(w_slot);
              r_state <= ST_DRIVE;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end

        ST_DONE: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign coin      = r_coin;
  assign rsp_vend  = r_vend;
  assign rsp_chg   = r_chg;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vend_coin_driver.sv
`default_nettype none
// ============================================================================
// tb_vend_coin_driver : directed vectors against a behavioural Mealy vending machine
// Revision            : 1.0
// ============================================================================
module tb_vend_coin_driver;

  localparam int MAX_COINS = 4;
  localparam int GAP       = 1;
  localparam int CW        = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2*MAX_COINS-1:0] cmd_coins;
  logic [CW-1:0]          cmd_len;
  logic [1:0]             coin;
  logic                   dispense;
  logic                   chg5;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CW-1:0]          rsp_vend;
  logic [CW-1:0]          rsp_chg;
  logic                   rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder modes: 0 normal Mealy, 1 dispense forced low, 2 dispense on every coin pulse.
  int   mode = 0;
  logic idle_stray = 1'b0;

  int   m_credit;
  int   m_sum;
  logic m_disp;
  logic m_chg;

  always #5 clk = ~clk;

  vend_coin_driver #(.MAX_COINS(MAX_COINS), .GAP(GAP), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_coins (cmd_coins),
    .cmd_len   (cmd_len),
    .coin      (coin),
    .dispense  (dispense),
    .chg5      (chg5),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_vend  (rsp_vend),
    .rsp_chg   (rsp_chg),
    .rsp_err   (rsp_err)
  );

  always_comb begin
    m_sum  = m_credit + ((coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0);
    m_disp = (m_sum >= 20);
    m_chg  = (m_sum == 25);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_credit <= 0;
    else        m_credit <= (m_sum >= 20) ? 0 : m_sum;
  end

  assign dispense = (mode == 1) ? 1'b0 : (m_disp | ((mode == 2) && (coin != 2'b00)) | idle_stray);
  assign chg5     = m_chg;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_cmd(input logic [CW-1:0] len, input logic [7:0] coins, input int hold,
                         output int v, output int c, output int e, output int p);
    int to;
    int bad;
    p  = 0;
    to = 1;
    @(negedge clk);
    cmd_len   = len;
    cmd_coins = coins;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (coin != 2'b00) p++;
      if (rsp_valid) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    check("rsp_timeout", to, 0);
    v   = int'(rsp_vend);
    c   = int'(rsp_chg);
    e   = int'(rsp_err);
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || coin != 2'b00 || int'(rsp_vend) != v ||
          int'(rsp_chg) != c || int'(rsp_err) != e) bad++;
    end
    if (hold > 0) check("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", int'({rsp_valid, cmd_ready}), 1);
  endtask

  typedef struct {
    logic [CW-1:0] len;
    logic [7:0]    coins;
    int            mode;
    int            e_vend;
    int            e_chg;
    int            e_err;
    int            e_pulses;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, c, e, p, to;

    // Slot 0 sits in bits [1:0]; model credit carries from row to row.
    vecs[0] = '{3'd2, 8'h0A, 0, 1, 0, 0, 2};  // {10,10}
    vecs[1] = '{3'd3, 8'h25, 0, 1, 0, 0, 3};  // {5,5,10}
    vecs[2] = '{3'd3, 8'h26, 0, 1, 1, 0, 3};  // {10,5,10}
    vecs[3] = '{3'd1, 8'h03, 0, 0, 0, 1, 0};  // illegal code
    vecs[4] = '{3'd5, 8'h55, 0, 0, 0, 1, 0};  // length over MAX_COINS
    vecs[5] = '{3'd0, 8'h0A, 0, 0, 0, 0, 0};  // empty command
    vecs[6] = '{3'd2, 8'h0A, 1, 0, 0, 1, 2};  // dispense held low
    vecs[7] = '{3'd1, 8'h01, 2, 1, 0, 1, 1};  // unexpected dispense, credit left at 5
    vecs[8] = '{3'd2, 8'h09, 0, 1, 0, 0, 2};  // {5,10} on top of 5 -> 20
    vecs[9] = '{3'd0, 8'h00, 0, 0, 0, 0, 0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_coins = '0;
    cmd_len   = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coin",      int'(coin),      0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_vend",      int'(rsp_vend),  0);
    check("rst_chg",       int'(rsp_chg),   0);
    check("rst_err",       int'(rsp_err),   0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      mode = vecs[i].mode;
      run_cmd(vecs[i].len, vecs[i].coins, 0, v, c, e, p);
      mode = 0;
      check($sformatf("row%0d_vend", i),   v, vecs[i].e_vend);
      check($sformatf("row%0d_chg", i),    c, vecs[i].e_chg);
      check($sformatf("row%0d_err", i),    e, vecs[i].e_err);
      check($sformatf("row%0d_pulses", i), p, vecs[i].e_pulses);
    end

    // Stray dispense while idle after an empty command.
    @(negedge clk);
    idle_stray = 1'b1;
    @(negedge clk);
    idle_stray = 1'b0;
    check("idle_stray_err",  int'(rsp_err),  1);
    check("idle_stray_vend", int'(rsp_vend), 1);

    // Reset during the gap after the second coin of {5,5,10}.
    @(negedge clk);
    cmd_len   = 3'd3;
    cmd_coins = 8'h25;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    p  = 0;
    to = 1;
    for (int k = 0; k < 50; k++) begin
      if (coin != 2'b00) p++;
      if (p == 2) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    check("mid_second_pulse", to, 0);
    @(negedge clk);
    check("mid_in_gap", int'(coin), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_coin",      int'(coin),      0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(3'd2, 8'h0A, 0, v, c, e, p);
    check("post_rst_vend",   v, 1);
    check("post_rst_chg",    c, 0);
    check("post_rst_err",    e, 0);
    check("post_rst_pulses", p, 2);

    // Response held for 10 cycles with rsp_ready low.
    run_cmd(3'd2, 8'h0A, 10, v, c, e, p);
    check("bp_vend", v, 1);
    check("bp_err",  e, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
